// File: rtl/ps2_pkg.sv
// Shared constants, receiver state type and the scan-code set 2 to ASCII map
// for the PS/2 keyboard front end.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [6:0] ASCII_CR  = 7'h0D;

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_e;

  // Returns {valid, ascii[6:0]}; letters are uppercase in both shift states.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic shift);
    logic [6:0] lo;
    logic [6:0] hi;
    logic       v;
    lo = 7'h00;
    hi = 7'h00;
    v  = 1'b1;
    case (code)
      8'h1C: {lo, hi} = {7'h41, 7'h41};
      8'h32: {lo, hi} = {7'h42, 7'h42};
      8'h21: {lo, hi} = {7'h43, 7'h43};
      8'h23: {lo, hi} = {7'h44, 7'h44};
      8'h24: {lo, hi} = {7'h45, 7'h45};
      8'h2B: {lo, hi} = {7'h46, 7'h46};
      8'h34: {lo, hi} = {7'h47, 7'h47};
      8'h33: {lo, hi} = {7'h48, 7'h48};
      8'h43: {lo, hi} = {7'h49, 7'h49};
      8'h3B: {lo, hi} = {7'h4A, 7'h4A};
      8'h42: {lo, hi} = {7'h4B, 7'h4B};
      8'h4B: {lo, hi} = {7'h4C, 7'h4C};
      8'h3A: {lo, hi} = {7'h4D, 7'h4D};
      8'h31: {lo, hi} = {7'h4E, 7'h4E};
      8'h44: {lo, hi} = {7'h4F, 7'h4F};
      8'h4D: {lo, hi} = {7'h50, 7'h50};
      8'h15: {lo, hi} = {7'h51, 7'h51};
      8'h2D: {lo, hi} = {7'h52, 7'h52};
      8'h1B: {lo, hi} = {7'h53, 7'h53};
      8'h2C: {lo, hi} = {7'h54, 7'h54};
      8'h3C: {lo, hi} = {7'h55, 7'h55};
      8'h2A: {lo, hi} = {7'h56, 7'h56};
      8'h1D: {lo, hi} = {7'h57, 7'h57};
      8'h22: {lo, hi} = {7'h58, 7'h58};
      8'h35: {lo, hi} = {7'h59, 7'h59};
      8'h1A: {lo, hi} = {7'h5A, 7'h5A};
      8'h45: {lo, hi} = {7'h30, 7'h29};
      8'h16: {lo, hi} = {7'h31, 7'h21};
      8'h1E: {lo, hi} = {7'h32, 7'h40};
      8'h26: {lo, hi} = {7'h33, 7'h23};
      8'h25: {lo, hi} = {7'h34, 7'h24};
      8'h2E: {lo, hi} = {7'h35, 7'h25};
      8'h36: {lo, hi} = {7'h36, 7'h5E};
      8'h3D: {lo, hi} = {7'h37, 7'h26};
      8'h3E: {lo, hi} = {7'h38, 7'h2A};
      8'h46: {lo, hi} = {7'h39, 7'h28};
      8'h29: {lo, hi} = {7'h20, 7'h20};
      8'h5A: {lo, hi} = {7'h0D, 7'h0D};
      8'h66: {lo, hi} = {7'h5F, 7'h5F};
      8'h76: {lo, hi} = {7'h1B, 7'h1B};
      8'h41: {lo, hi} = {7'h2C, 7'h3C};
      8'h49: {lo, hi} = {7'h2E, 7'h3E};
      8'h4A: {lo, hi} = {7'h2F, 7'h3F};
      8'h4C: {lo, hi} = {7'h3B, 7'h3A};
      8'h52: {lo, hi} = {7'h27, 7'h22};
      8'h4E: {lo, hi} = {7'h2D, 7'h5F};
      8'h55: {lo, hi} = {7'h3D, 7'h2B};
      8'h54: {lo, hi} = {7'h5B, 7'h7B};
      8'h5B: {lo, hi} = {7'h5D, 7'h7D};
      8'h5D: {lo, hi} = {7'h5C, 7'h7C};
      8'h0E: {lo, hi} = {7'h60, 7'h7E};
      default: v = 1'b0;
    endcase
    return {v, shift ? hi : lo};
  endfunction

endpackage

// File: rtl/ps2_ascii_if.sv
// Keyboard-side lines and ASCII output of the PS/2 front end; the design
// takes the slave view, the keyboard/host environment the master view.
interface ps2_ascii_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [6:0] ascii_code;
  logic       ascii_new;

  modport master (output ps2_clk, output ps2_data, input ascii_code, input ascii_new);
  modport slave  (input ps2_clk, input ps2_data, output ascii_code, output ascii_new);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronisers, ps2_clk glitch filter, frame FSM and
// idle timeout. Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o
);

  // Divide before multiplying so 50 MHz x 200 us stays inside 32 bits.
  localparam int TIMEOUT_CYCLES = TIMEOUT_US * (CLK_FREQ_HZ / 1_000_000);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FL_W = $clog2(FILTER_LEN + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FL_W-1:0] FL_LAST  = FL_W'(FILTER_LEN - 1);
  localparam logic [3:0]      LAST_BIT = 4'(FRAME_BITS - 2);

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            clk_filt_q, fall_q;
  logic [FL_W-1:0] flt_cnt_q;
  logic            data_s;

  assign data_s = data_sync_q[1];

  always_ff @(posedge clk) begin
    // NOTE: every clocked register uses <= so all flops sample the same pre-edge values.
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      fall_q      <= 1'b0;
      flt_cnt_q   <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      fall_q      <= 1'b0;
      if (clk_sync_q[1] == clk_filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FL_LAST) begin
        clk_filt_q <= clk_sync_q[1];
        flt_cnt_q  <= '0;
        fall_q     <= ~clk_sync_q[1];
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  rx_state_e       state_q, state_d;
  logic [9:0]      sr_q, sr_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            frame_ok;

  always_ff @(posedge clk) begin
    if (reset) state_q <= RX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps paths without an assignment from inferring latches.
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall_q && !data_s) state_d = RX_SHIFT;
      RX_SHIFT: begin
        if (fall_q && bit_cnt_q == LAST_BIT) state_d = RX_CHECK;
        else if (!fall_q && to_cnt_q == TO_LAST) state_d = RX_IDLE;
      end
      RX_CHECK: state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Shift register fills from the top: after ten edges sr = {stop, parity, D7..D0}.
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    if (state_q == RX_SHIFT) begin
      if (fall_q) begin
        sr_d      = {data_s, sr_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      bit_cnt_d = '0;
      to_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = sr_q[9] & (^sr_q[8:0]);
`else
    frame_ok = sr_q[9];
`endif
    rx_valid_o = (state_q == RX_CHECK) && frame_ok;
    rx_byte_o  = sr_q[7:0];
  end

endmodule

// File: rtl/ps2_ascii_top.sv
// PS/2 keyboard front end: receiver plus make/break/extended/shift decoder
// driving a held 7-bit ASCII code and a one-cycle strobe.
module ps2_ascii_top
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 200
) (
  input  logic        clk,
  input  logic        reset,
  ps2_ascii_if.slave  bus
);

  logic [7:0] rx_byte;
  logic       rx_valid;

  ps2_rx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_US  (TIMEOUT_US)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk_i  (bus.ps2_clk),
    .ps2_data_i (bus.ps2_data),
    .rx_byte_o  (rx_byte),
    .rx_valid_o (rx_valid)
  );

  logic       ext_q, ext_d, brk_q, brk_d, shift_q, shift_d, new_q, new_d;
  logic [6:0] code_q, code_d;
  logic [7:0] lut;
  logic       is_shift;

  assign lut      = scan_to_ascii(rx_byte, shift_q);
  assign is_shift = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    shift_d = shift_q;
    code_d  = code_q;
    new_d   = 1'b0;
    if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (is_shift) begin
          shift_d = ~brk_q;
        end else if (brk_q) begin
          shift_d = shift_q;
        end else if (ext_q) begin
          // Keypad Enter is the only extended key the Apple-1 keyboard needs.
          if (rx_byte == SC_ENTER) begin
            code_d = ASCII_CR;
            new_d  = 1'b1;
          end
        end else if (lut[7]) begin
          code_d = lut[6:0];
          new_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      shift_q <= 1'b0;
      code_q  <= '0;
      new_q   <= 1'b0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      shift_q <= shift_d;
      code_q  <= code_d;
      new_q   <= new_d;
    end
  end

  assign bus.ascii_code = code_q;
  assign bus.ascii_new  = new_q;

endmodule

// File: tb/tb_ps2_ascii_top.sv
// Directed bench for ps2_ascii_top; clock scaled to 1 MHz so every us of PS/2
// timing is one clk. Expectations follow PS2_PARITY_CHECK_EN when defined.
`timescale 1ns/1ps
module tb_ps2_ascii_top;

  localparam int  CLK_HZ   = 1_000_000;
  localparam int  FILTER   = 8;
  localparam int  TO_US    = 200;
  localparam int  LAT_MAX  = 2 * FILTER + 8;
  localparam time HALF_BIT = 43200;

  logic clk = 1'b0;
  logic reset;
  ps2_ascii_if bus ();

  always #500 clk = ~clk;

  ps2_ascii_top #(
    .CLK_FREQ_HZ (CLK_HZ),
    .FILTER_LEN  (FILTER),
    .TIMEOUT_US  (TO_US)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         cyc = 0;
  int         stop_cyc = 0;
  int         strobe_cyc = 0;
  int         run = 0;
  int         max_run = 0;
  logic [6:0] codes[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         exp_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the code seen alongside it, and the longest pulse.
  always @(negedge clk) begin
    if (bus.ascii_new === 1'b1) begin
      codes.push_back(bus.ascii_code);
      strobe_cyc <= cyc;
      run        <= run + 1;
      if (run + 1 > max_run) max_run <= run + 1;
    end else begin
      run <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_us(input int us);
    #(us * 1000);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = f[i];
      #(HALF_BIT);
      bus.ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      #(HALF_BIT);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic send_seq(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
    idle_us(150);
  endtask

  function automatic logic [6:0] code_at(input int idx);
    if (idx < codes.size()) return codes[idx];
    return 7'h7F;
  endfunction

  initial begin
    reset        = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_code", 32'(bus.ascii_code), 32'h00);
    check("reset_new", 32'(bus.ascii_new), 32'h0);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("idle_no_strobe", 32'(codes.size()), 32'(exp_n));

    // Two plain 'A' presses 500 us apart, with latency of the first.
    send_frame(8'h1C, 1'b0, 11);
    idle_us(100);
    exp_n++;
    check("a1_count", 32'(codes.size()), 32'(exp_n));
    check("a1_code", 32'(bus.ascii_code), 32'h41);
    check("a1_latency", 32'((strobe_cyc - stop_cyc) > 0 && (strobe_cyc - stop_cyc) <= LAT_MAX), 32'h1);
    idle_us(400);
    send_frame(8'h1C, 1'b0, 11);
    idle_us(100);
    exp_n++;
    check("a2_count", 32'(codes.size()), 32'(exp_n));
    check("a2_code", 32'(code_at(exp_n - 1)), 32'h41);

    // Break of 'A' is silent; the next make strobes again.
    send_seq(8'hF0);
    send_seq(8'h1C);
    check("brk_count", 32'(codes.size()), 32'(exp_n));
    check("brk_code_held", 32'(bus.ascii_code), 32'h41);
    send_seq(8'h1C);
    exp_n++;
    check("remake_count", 32'(codes.size()), 32'(exp_n));
    check("remake_code", 32'(bus.ascii_code), 32'h41);

    // Shift + '1', release shift, '1' again.
    send_seq(8'h12);
    send_seq(8'h16);
    send_seq(8'hF0);
    send_seq(8'h12);
    send_seq(8'h16);
    exp_n += 2;
    check("shift_count", 32'(codes.size()), 32'(exp_n));
    check("shift_bang", 32'(code_at(exp_n - 2)), 32'h21);
    check("unshift_one", 32'(code_at(exp_n - 1)), 32'h31);

    // 'A' with a wrong parity bit.
    send_seq(8'h45);
    exp_n++;
    check("zero_code", 32'(bus.ascii_code), 32'h30);
    send_frame(8'h1C, 1'b1, 11);
    idle_us(150);
`ifdef PS2_PARITY_CHECK_EN
    check("badpar_count", 32'(codes.size()), 32'(exp_n));
    check("badpar_code", 32'(bus.ascii_code), 32'h30);
`else
    exp_n++;
    check("badpar_count", 32'(codes.size()), 32'(exp_n));
    check("badpar_code", 32'(bus.ascii_code), 32'h41);
`endif

    // Extended keys: cursor-up is silent, keypad Enter gives CR.
    send_seq(8'h29);
    exp_n++;
    check("space_code", 32'(bus.ascii_code), 32'h20);
    send_seq(8'hE0);
    send_seq(8'h75);
    check("ext_up_count", 32'(codes.size()), 32'(exp_n));
    send_seq(8'hE0);
    send_seq(8'h5A);
    exp_n++;
    check("kp_enter_count", 32'(codes.size()), 32'(exp_n));
    check("kp_enter_code", 32'(bus.ascii_code), 32'h0D);

    // Unmapped code (F1) leaves the output alone.
    send_seq(8'h66);
    exp_n++;
    check("rubout_code", 32'(bus.ascii_code), 32'h5F);
    send_seq(8'h05);
    check("unmapped_count", 32'(codes.size()), 32'(exp_n));
    check("unmapped_code", 32'(bus.ascii_code), 32'h5F);

    // Truncated frame, 1 ms idle, then a full Enter frame.
    send_frame(8'h5A, 1'b0, 4);
    idle_us(1000);
    check("partial_count", 32'(codes.size()), 32'(exp_n));
    send_seq(8'h5A);
    exp_n++;
    check("timeout_count", 32'(codes.size()), 32'(exp_n));
    check("timeout_code", 32'(bus.ascii_code), 32'h0D);

    // Reset mid-frame, then a frame sent well inside the timeout window.
    send_frame(8'h1C, 1'b0, 4);
    @(posedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset_code", 32'(bus.ascii_code), 32'h00);
    send_seq(8'h76);
    exp_n++;
    check("midreset_count", 32'(codes.size()), 32'(exp_n));
    check("midreset_esc", 32'(bus.ascii_code), 32'h1B);

    check("strobe_width", 32'(max_run), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
